// File: rtl/bus_router_pkg.sv
// Shared types and default SoC address map for the bus router.
package bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR
    } router_state_t;

    // Default SoC address map (exclusive top addresses).
    localparam logic [31:0] BRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] BRAM_TOP   = 32'h0010_0000;
    localparam logic [31:0] PRINT_BASE = 32'h0100_0000;
    localparam logic [31:0] PRINT_TOP  = 32'h0100_0004;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
    localparam logic [31:0] ROM_BASE   = 32'h1000_0000;
    localparam logic [31:0] ROM_TOP    = 32'h1000_1000;

    // Slave 0 occupies the least significant word.
    localparam int unsigned      MAP_NSLV     = 4;
    localparam logic [4*32-1:0]  MAP_SLV_BASE = {ROM_BASE, CLINT_BASE, PRINT_BASE, BRAM_BASE};
    localparam logic [4*32-1:0]  MAP_SLV_TOP  = {ROM_TOP, CLINT_TOP, PRINT_TOP, BRAM_TOP};

    // Width of an encoded slave index; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_router_decode.sv
// Combinational address window decode: one-hot hit, hit flag, encoded index.
module bus_router_decode
    import bus_router_pkg::*;
#(
    parameter int unsigned        NSLV     = 4,
    parameter int unsigned        AW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_TOP  = '0,
    localparam int unsigned       IW       = idx_width(NSLV)
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] hit_onehot,
    output logic            hit,
    output logic [IW-1:0]   hit_idx
);

    logic [NSLV-1:0] hit_raw;

    // Window compare per slave, then keep only the lowest matching index.
    always_comb begin
        hit_raw    = '0;
        hit_onehot = '0;
        hit        = 1'b0;
        hit_idx    = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            hit_raw[i] = (addr >= SLV_BASE[i*AW +: AW]) && (addr < SLV_TOP[i*AW +: AW]);
        end
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (hit_raw[i] && !hit) begin
                hit           = 1'b1;
                hit_onehot[i] = 1'b1;
                hit_idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_router.sv
// Routes one upstream memory channel to NSLV address-mapped slave channels.
module bus_router
    import bus_router_pkg::*;
#(
    parameter int unsigned        NSLV     = 4,
    parameter int unsigned        AW       = 32,
    parameter int unsigned        DW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_TOP  = '0,
    parameter int unsigned        TIMEOUT  = 1023,
    localparam int unsigned       SW       = DW / 8,
    localparam int unsigned       IW       = idx_width(NSLV),
    localparam int unsigned       TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               memory_valid,
    input  logic               memory_instr,
    input  logic [AW-1:0]      memory_addr,
    input  logic [DW-1:0]      memory_wdata,
    input  logic [SW-1:0]      memory_wstrb,
    output logic [DW-1:0]      memory_rdata,
    output logic               memory_ready,
    output logic               memory_error,
    output logic [NSLV-1:0]    slv_valid,
    output logic [NSLV-1:0]    slv_instr,
    output logic [NSLV*AW-1:0] slv_addr,
    output logic [NSLV*DW-1:0] slv_wdata,
    output logic [NSLV*SW-1:0] slv_wstrb,
    input  logic [NSLV*DW-1:0] slv_rdata,
    input  logic [NSLV-1:0]    slv_ready,
    output logic               busy
);

    router_state_t   state, state_next;
    logic [IW-1:0]   sel, sel_next;
    logic [TW-1:0]   timer, timer_next;
    logic [NSLV-1:0] hit_onehot;
    logic            hit_any;
    logic [IW-1:0]   hit_idx;
    logic [NSLV-1:0] fwd;

    bus_router_decode #(
        .NSLV     (NSLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_TOP  (SLV_TOP)
    ) u_decode (
        .addr       (memory_addr),
        .hit_onehot (hit_onehot),
        .hit        (hit_any),
        .hit_idx    (hit_idx)
    );

    // State, selected slave and BUSY watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            timer <= timer_next;
        end
    end

    // Next-state logic, response mux and zero-latency request forwarding.
    always_comb begin
        state_next   = state;
        sel_next     = sel;
        timer_next   = timer;
        memory_rdata = '0;
        memory_ready = 1'b0;
        memory_error = 1'b0;
        slv_valid    = '0;
        slv_instr    = '0;
        slv_addr     = '0;
        slv_wdata    = '0;
        slv_wstrb    = '0;
        busy         = (state != ST_IDLE);
        fwd          = '0;

        case (state)
            ST_IDLE: begin
                if (memory_valid) begin
                    if (hit_any) begin
                        fwd        = hit_onehot;
                        state_next = ST_BUSY;
                        sel_next   = hit_idx;
                        timer_next = '0;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                memory_ready = slv_ready[sel];
                memory_rdata = slv_rdata[sel*DW +: DW];
                if (slv_ready[sel]) begin
                    state_next = ST_IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_next = ST_ERR;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            ST_ERR: begin
                memory_ready = 1'b1;
                memory_error = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        slv_valid = fwd;
        for (int unsigned i = 0; i < NSLV; i++) begin
            slv_instr[i]           = fwd[i] & memory_instr;
            slv_addr[i*AW +: AW]   = memory_addr - SLV_BASE[i*AW +: AW];
            slv_wdata[i*DW +: DW]  = memory_wdata;
            slv_wstrb[i*SW +: SW]  = fwd[i] ? memory_wstrb : '0;
        end

        // Reset is synchronous, so the state may still be stale during the
        // first reset cycle; force every output quiet independently.
        if (reset) begin
            memory_rdata = '0;
            memory_ready = 1'b0;
            memory_error = 1'b0;
            slv_valid    = '0;
            slv_instr    = '0;
            slv_addr     = '0;
            slv_wdata    = '0;
            slv_wstrb    = '0;
            busy         = 1'b0;
        end
    end

endmodule
